// File: rtl/rng_scheduler.sv
// rng_scheduler: seeds a 10-bit serial LFSR, discards warm-up bits, then serves
// WORD_W-bit words to NUM_REQ round-robin requesters. Optional macro: RNG_LOCKUP_DET_EN.

module rng_scheduler #(
   parameter int NUM_REQ = 4,
   parameter int WORD_W  = 6,
   parameter int WARMUP  = 16
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [9:0]         seed_in,
   input  logic               seed_go,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] grant,
   output logic [WORD_W-1:0]  rnd_word,
   output logic               rnd_valid,
   output logic               seeded,
   output logic               rng_load_n,
   output logic [9:0]         rng_seed,
`ifdef RNG_LOCKUP_DET_EN
   output logic               lockup_seen,
`endif
   input  logic               rng_bit
);

   localparam int         PTR_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [9:0] SEED_SAFE = 10'h001;

   typedef enum logic [2:0] {
      ST_UNSEEDED = 3'd0,
      ST_LOAD     = 3'd1,
      ST_WARMUP   = 3'd2,
      ST_READY    = 3'd3,
      ST_COLLECT  = 3'd4,
      ST_DELIVER  = 3'd5
   } state_t;

   state_t               state_q, state_d;
   logic [9:0]           rng_seed_q, rng_seed_d;
   logic [7:0]           warm_cnt_q, warm_cnt_d;
   logic [3:0]           bit_cnt_q, bit_cnt_d;
   logic [WORD_W-1:0]    word_q, word_d;
   logic [PTR_W-1:0]     ptr_q, ptr_d;
   logic [PTR_W-1:0]     winner_q, winner_d;
   logic [NUM_REQ-1:0]   grant_q, grant_d;
   logic [WORD_W-1:0]    rnd_word_q, rnd_word_d;
   logic                 rnd_valid_q, rnd_valid_d;
   logic                 seeded_q, seeded_d;
   logic                 rng_load_n_q, rng_load_n_d;
   logic                 rng_bit_q, rng_bit_d;
   logic [PTR_W-1:0]     pick;
   logic                 reload;
   logic [9:0]           reload_seed;
   logic [9:0]           user_seed;
`ifdef RNG_LOCKUP_DET_EN
   logic [4:0]           run_q, run_d;
   logic                 lockup_q, lockup_d;
   logic                 stuck;
`endif

   // First requester at or after p, wrapping past NUM_REQ-1 back to 0.
   function automatic logic [PTR_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                                input logic [PTR_W-1:0]   p);
      logic [NUM_REQ-1:0] rot;
      int                 off;
      int                 sum;
      rot = NUM_REQ'({r, r} >> p);
      off = 0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (rot[k]) begin
            off = k;
         end else begin
            off = off;
         end
      end
      sum = int'(p) + off;
      sum = (sum >= NUM_REQ) ? (sum - NUM_REQ) : sum;
      return PTR_W'(sum);
   endfunction

   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] w);
      int n;
      n = int'(w) + 1;
      return (n >= NUM_REQ) ? {PTR_W{1'b0}} : PTR_W'(n);
   endfunction

   assign pick = rr_pick(req, ptr_q);

   // Next-state and next-output computation for the whole controller.
   always_comb begin
      state_d      = state_q;
      rng_seed_d   = rng_seed_q;
      warm_cnt_d   = warm_cnt_q;
      bit_cnt_d    = bit_cnt_q;
      word_d       = word_q;
      ptr_d        = ptr_q;
      winner_d     = winner_q;
      grant_d      = grant_q;
      rnd_word_d   = rnd_word_q;
      rnd_valid_d  = 1'b0;
      seeded_d     = seeded_q;
      rng_load_n_d = 1'b1;
      rng_bit_d    = rng_bit;
      user_seed    = (seed_in == 10'h000) ? SEED_SAFE : seed_in;
      reload       = seed_go && (state_q != ST_LOAD);
      reload_seed  = user_seed;
`ifdef RNG_LOCKUP_DET_EN
      // A run of identical bits only counts while words are being served.
      if ((state_q == ST_READY) || (state_q == ST_COLLECT) || (state_q == ST_DELIVER)) begin
         run_d = ((run_q != 5'd0) && (rng_bit == rng_bit_q)) ? (run_q + 5'd1) : 5'd1;
      end else begin
         run_d = 5'd0;
      end
      stuck       = (run_d == 5'd20);
      lockup_d    = lockup_q | stuck;
      reload      = reload | stuck;
      reload_seed = stuck ? SEED_SAFE : user_seed;
`endif

      if (reload) begin
         state_d      = ST_LOAD;
         rng_seed_d   = reload_seed;
         rng_load_n_d = 1'b0;
         grant_d      = {NUM_REQ{1'b0}};
         seeded_d     = 1'b0;
         warm_cnt_d   = 8'd0;
         bit_cnt_d    = 4'd0;
      end else begin
         case (state_q)
            ST_UNSEEDED: begin
               grant_d = {NUM_REQ{1'b0}};
            end
            ST_LOAD: begin
               state_d    = ST_WARMUP;
               warm_cnt_d = 8'd0;
            end
            ST_WARMUP: begin
               if (int'(warm_cnt_q) == WARMUP - 1) begin
                  state_d  = ST_READY;
                  seeded_d = 1'b1;
               end else begin
                  warm_cnt_d = warm_cnt_q + 8'd1;
               end
            end
            ST_READY: begin
               if (req != {NUM_REQ{1'b0}}) begin
                  state_d   = ST_COLLECT;
                  winner_d  = pick;
                  grant_d   = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick;
                  bit_cnt_d = 4'd0;
               end else begin
                  state_d = ST_READY;
               end
            end
            ST_COLLECT: begin
               if ((req & grant_q) == {NUM_REQ{1'b0}}) begin
                  state_d   = ST_READY;
                  grant_d   = {NUM_REQ{1'b0}};
                  ptr_d     = ptr_next(winner_q);
                  bit_cnt_d = 4'd0;
               end else begin
                  // rng_bit_q is one cycle old, so the READY-cycle bit lands in the MSB.
                  for (int i = 0; i < WORD_W; i++) begin
                     if (int'(bit_cnt_q) == WORD_W - 1 - i) begin
                        word_d[i] = rng_bit_q;
                     end else begin
                        word_d[i] = word_q[i];
                     end
                  end
                  if (int'(bit_cnt_q) == WORD_W - 1) begin
                     state_d     = ST_DELIVER;
                     rnd_valid_d = 1'b1;
                     rnd_word_d  = word_d;
                     bit_cnt_d   = 4'd0;
                  end else begin
                     bit_cnt_d = bit_cnt_q + 4'd1;
                  end
               end
            end
            ST_DELIVER: begin
               state_d = ST_READY;
               grant_d = {NUM_REQ{1'b0}};
               ptr_d   = ptr_next(winner_q);
            end
            default: begin
               state_d = ST_UNSEEDED;
               grant_d = {NUM_REQ{1'b0}};
            end
         endcase
      end
   end

   // State and output registers; reset returns everything to the unseeded idle state.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= ST_UNSEEDED;
         rng_seed_q   <= 10'h000;
         warm_cnt_q   <= 8'd0;
         bit_cnt_q    <= 4'd0;
         word_q       <= {WORD_W{1'b0}};
         ptr_q        <= {PTR_W{1'b0}};
         winner_q     <= {PTR_W{1'b0}};
         grant_q      <= {NUM_REQ{1'b0}};
         rnd_word_q   <= {WORD_W{1'b0}};
         rnd_valid_q  <= 1'b0;
         seeded_q     <= 1'b0;
         rng_load_n_q <= 1'b1;
         rng_bit_q    <= 1'b0;
`ifdef RNG_LOCKUP_DET_EN
         run_q        <= 5'd0;
         lockup_q     <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         rng_seed_q   <= rng_seed_d;
         warm_cnt_q   <= warm_cnt_d;
         bit_cnt_q    <= bit_cnt_d;
         word_q       <= word_d;
         ptr_q        <= ptr_d;
         winner_q     <= winner_d;
         grant_q      <= grant_d;
         rnd_word_q   <= rnd_word_d;
         rnd_valid_q  <= rnd_valid_d;
         seeded_q     <= seeded_d;
         rng_load_n_q <= rng_load_n_d;
         rng_bit_q    <= rng_bit_d;
`ifdef RNG_LOCKUP_DET_EN
         run_q        <= run_d;
         lockup_q     <= lockup_d;
`endif
      end
   end

   assign grant      = grant_q;
   assign rnd_word   = rnd_word_q;
   assign rnd_valid  = rnd_valid_q;
   assign seeded     = seeded_q;
   assign rng_load_n = rng_load_n_q;
   assign rng_seed   = rng_seed_q;
`ifdef RNG_LOCKUP_DET_EN
   assign lockup_seen = lockup_q;
`endif

endmodule
